fir_filter_param: RTL and testbench
===================================

// Module: fir_filter_param
// PURPOSE
//   Parametrised direct-form FIR filter; successor to the fixed 11-tap, 9-bit lab filter.
//   Tap count, data/coefficient width, pipelining and output overflow mode are generics.
//   Coefficients are loaded at run time through a write port instead of parallel pins.
//   Sits between the sample source (data maker) and the sample consumer (data sink).
//   Both use the same VIN/VOUT valid-strobe interface.
// PARAMETERS
//   N_TAPS   11  number of taps (order N_TAPS-1), >= 2
//   DATA_W    9  signed two's-complement width of DIN and DOUT
//   COEF_W    9  signed width of coefficients; Q1.(COEF_W-1) fractional format
//   PIPE      1  0: latency 1, single output register; 1: adds product register, latency 2
//   SAT       1  1: saturate output to DATA_W range; 0: truncate (two's-complement wrap)
// PORTS
//   CLK        in   1                   clock, rising edge
//   RST        in   1                   asynchronous reset, active-high
//   CLR        in   1                   synchronous flush of delay line and pipeline
//   DIN        in   DATA_W              input sample, signed
//   VIN        in   1                   DIN valid; the sample is accepted on the rising edge where VIN=1
//   COEF_WE    in   1                   coefficient write enable
//   COEF_ADDR  in   clog2(N_TAPS)       tap index k of coefficient b_k
//   COEF_DATA  in   COEF_W              coefficient value, signed
//   DOUT       out  DATA_W              filtered sample, signed, registered
//   VOUT       out  1                   DOUT valid strobe, one cycle per accepted sample
// BEHAVIOUR
//   Reset (RST=1, async): delay line, all coefficients, pipeline registers, DOUT and VOUT -> 0.
//     Reset has priority over everything; in-flight samples are discarded, no VOUT afterwards.
//   Delay line x[1..N_TAPS-1] shifts only on edges with VIN=1: x[1]<=DIN, x[k]<=x[k-1].
//     With VIN=0 the delay line holds, so gaps in VIN do not insert zeros.
//   y = b_0*DIN + sum_{k=1..N_TAPS-1} b_k*x[k], formed from the values present in the accept cycle.
//   Arithmetic:
//     - Products are DATA_W+COEF_W bits.
//     - The accumulator is DATA_W+COEF_W+clog2(N_TAPS) bits and never overflows.
//     - Result = acc >>> (COEF_W-1), arithmetic shift (floor, no rounding).
//     - SAT=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. SAT=0: keep the low DATA_W bits.
//   Latency: VOUT=1 exactly 1+PIPE cycles after the accept edge, for one cycle per sample.
//     Back-to-back VIN gives back-to-back VOUT. DOUT holds its last value while VOUT=0.
//   Coefficient write: on an edge with COEF_WE=1 and COEF_ADDR<N_TAPS, b[COEF_ADDR]<=COEF_DATA.
//     COEF_ADDR>=N_TAPS: the write is ignored.
//     A sample accepted on the same edge as a write uses the old coefficient.
//       The new value applies from the next accepted sample.
//     PIPE=1: products are captured at accept, so a later write never alters an in-flight sample.
//   CLR=1 (sync):
//     - zeroes the delay line and the product register, clears pending valids, forces VOUT=0;
//     - coefficients are kept;
//     - CLR has priority over VIN on the same edge, so that sample is dropped.
//   No back-pressure: the consumer must accept every VOUT strobe.
// TESTING (N_TAPS=11, DATA_W=9, COEF_W=9, PIPE=1, SAT=1 unless stated)
//   1 Impulse: all b_k=64 (0.25), then DIN=200 for one valid, then 0s with VIN=1 every cycle
//     -> 11 consecutive VOUT with DOUT=50, then DOUT=0. First VOUT 2 cycles after the impulse.
//   2 Saturation: all b_k=255, DIN=255 held, 11+ valids -> DOUT settles at 255.
//     DIN=-256 held -> DOUT=-256 (9'h100).
//     Same stimulus with SAT=0 -> DOUT=234 (2794 mod 512).
//   3 VIN gaps: impulse test with VIN pattern 1,0,0,1,0,1
//     -> the output sequence matches test 1 sample-for-sample.
//     -> each VOUT arrives exactly 2 cycles after its VIN; DOUT is stable between strobes.
//   4 Coefficient write race: COEF_WE for b_0 (64->128) on the same edge as DIN=100 valid
//     -> that output uses 64 (25). The next DIN=100 sample uses 128 (50 from the b_0 term).
//     A write to COEF_ADDR=11..15 leaves every b_k unchanged.
//   5 Flush/reset: CLR=1 with VIN=1 mid-stream -> the sample is dropped, VOUT=0 next cycle.
//     The next impulse produces clean output with no history.
//     RST pulsed between clock edges -> DOUT=0 and VOUT=0 immediately; no VOUT until new valids.
//     The coefficients read back 0, so the output is 0.

Source files
------------

// File: rtl/fir_filter_param.sv
// fir_filter_param: direct-form FIR filter with a run-time loadable coefficient bank.
// The tap count, the data and coefficient widths, an optional product pipeline stage
// and the output overflow mode (saturate or wrap) are all set by parameters.
// Coefficients use the Q1.(COEF_W-1) format, so the sum is shifted right by COEF_W-1.
//
// Valid-strobe semantics: a sample is accepted on any rising clk edge where vin=1 and
// clr=0. There is no ready signal. For every accepted sample, vout pulses for exactly
// one cycle, 1+PIPE cycles after the accept edge, and dout carries the result in that
// cycle. The consumer must take every strobe. dout holds its value while vout=0.
module fir_filter_param #(
  parameter int N_TAPS = 11,
  parameter int DATA_W = 9,
  parameter int COEF_W = 9,
  parameter int PIPE   = 1,
  parameter int SAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [DATA_W-1:0]         din,
  input  logic                      vin,
  input  logic                      coef_we,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  output logic [DATA_W-1:0]         dout,
  output logic                      vout
);

  localparam int ADDR_W = $clog2(N_TAPS);
  localparam int LOG_W  = $clog2(N_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + LOG_W;

  // Output clamp limits, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Coefficient bank b[0..N_TAPS-1].
  logic signed [COEF_W-1:0] b_q [0:N_TAPS-1];

  // Delay line x[1..N_TAPS-1]. x[0] is din itself, so no register is needed for it.
  logic signed [DATA_W-1:0] x_q [1:N_TAPS-1];

  // Tap inputs and products for the sample currently on din.
  logic signed [DATA_W-1:0] tap  [0:N_TAPS-1];
  logic signed [PROD_W-1:0] prod [0:N_TAPS-1];

  // Products feeding the adder tree: either live or registered, depending on PIPE.
  logic signed [PROD_W-1:0] sum_src [0:N_TAPS-1];
  logic                     out_en;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] y_next;

  logic accept;

  // Flush wins over a same-edge sample, so that sample is dropped.
  assign accept = vin & ~clr;

  // Coefficient bank writes. An address that matches no tap (>= N_TAPS) writes nothing.
  // A sample accepted on the same edge reads the old value, because this is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) b_q[k] <= '0;
    end else if (coef_we) begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (coef_addr == ADDR_W'(k)) b_q[k] <= coef_data;
      end
    end
  end

  // The delay line shifts only on accepted samples. A gap in vin holds the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < N_TAPS; k++) x_q[k] <= '0;
    end else if (clr) begin
      for (int k = 1; k < N_TAPS; k++) x_q[k] <= '0;
    end else if (vin) begin
      x_q[1] <= din;
      for (int k = 2; k < N_TAPS; k++) x_q[k] <= x_q[k-1];
    end
  end

  // Collect the taps and form the full-precision signed products.
  always_comb begin
    tap[0] = din;
    for (int k = 1; k < N_TAPS; k++) tap[k] = x_q[k];
    for (int k = 0; k < N_TAPS; k++) begin
      prod[k] = {{COEF_W{tap[k][DATA_W-1]}}, tap[k]} *
                {{DATA_W{b_q[k][COEF_W-1]}}, b_q[k]};
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic signed [PROD_W-1:0] prod_q [0:N_TAPS-1];
      logic                     vld_q;

      // Capture the products at accept time, so later coefficient writes cannot
      // affect a sample that is already in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
          vld_q <= 1'b0;
        end else if (clr) begin
          for (int k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= vin;
          if (vin) begin
            for (int k = 0; k < N_TAPS; k++) prod_q[k] <= prod[k];
          end
        end
      end

      // The adder tree reads the registered products.
      always_comb begin
        for (int k = 0; k < N_TAPS; k++) sum_src[k] = prod_q[k];
        out_en = vld_q;
      end
    end else begin : g_nopipe
      // The adder tree reads the live products. The output register is the only stage.
      always_comb begin
        for (int k = 0; k < N_TAPS; k++) sum_src[k] = prod[k];
        out_en = accept;
      end
    end
  endgenerate

  // Accumulate the products. The accumulator is wide enough that it can never overflow.
  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      acc = acc + {{LOG_W{sum_src[k][PROD_W-1]}}, sum_src[k]};
    end
  end

  // Rescale from Q1.(COEF_W-1) with a flooring arithmetic shift, then clamp or wrap.
  always_comb begin
    shifted = acc >>> (COEF_W-1);
    y_next  = shifted[DATA_W-1:0];
    if (SAT != 0) begin
      if (shifted > SAT_MAX)      y_next = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) y_next = SAT_MIN[DATA_W-1:0];
    end
  end

  // Output register. vout strobes once per sample. dout changes only on a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      vout <= 1'b0;
    end else if (clr) begin
      vout <= 1'b0;
    end else begin
      vout <= out_en;
      if (out_en) dout <= y_next;
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// tb_fir_filter_param: directed bench for fir_filter_param.
// Three instances share the same stimulus:
//   u_dut    PIPE=1, SAT=1 (main configuration)
//   u_dut_w  PIPE=1, SAT=0 (wrap mode)
//   u_dut_z  PIPE=0, SAT=1 (latency-1 variant)
module tb_fir_filter_param;

  localparam int W = 9;

  logic         clk;
  logic         rst;
  logic         clr;
  logic [W-1:0] din;
  logic         vin;
  logic         coef_we;
  logic [3:0]   coef_addr;
  logic [W-1:0] coef_data;

  logic [W-1:0] dout_a, dout_w, dout_z;
  logic         vout_a, vout_w, vout_z;

  int n_tests;
  int n_fail;

  // Expected output queue for the impulse sequences.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int           last_exp;

  fir_filter_param #(.N_TAPS(11), .DATA_W(9), .COEF_W(9), .PIPE(1), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .vin(vin),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout(dout_a), .vout(vout_a)
  );

  fir_filter_param #(.N_TAPS(11), .DATA_W(9), .COEF_W(9), .PIPE(1), .SAT(0)) u_dut_w (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .vin(vin),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout(dout_w), .vout(vout_w)
  );

  fir_filter_param #(.N_TAPS(11), .DATA_W(9), .COEF_W(9), .PIPE(0), .SAT(1)) u_dut_z (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .vin(vin),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout(dout_z), .vout(vout_z)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [W-1:0] data);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic load_all(input logic [W-1:0] data);
    for (int k = 0; k < 11; k++) write_coef(4'(k), data);
  endtask

  // One isolated sample. The PIPE=0 copy answers after one edge; the others after two.
  task automatic send_chk(input logic [W-1:0] d, input int exp, input string tag);
    vin = 1'b1; din = d;
    tick();
    vin = 1'b0; din = '0;
    check({tag, "_vout_z"}, int'(vout_z), 1);
    check({tag, "_dout_z"}, $signed(dout_z), exp);
    check({tag, "_early_a"}, int'(vout_a), 0);
    tick();
    check({tag, "_vout_a"}, int'(vout_a), 1);
    check({tag, "_dout_a"}, $signed(dout_a), exp);
  endtask

  task automatic push_impulse_seq();
    for (int i = 0; i < 11; i++) exp_q.push_back(9'd50);
    exp_q.push_back(9'd0);
  endtask

  initial begin
    int pat [6];
    int acc_cnt;
    logic prev;
    pat = '{1, 0, 0, 1, 0, 1};
    n_tests = 0; n_fail = 0;
    rst = 1'b1; clr = 1'b0; din = '0; vin = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_vout", int'(vout_a), 0);
    check("rst_dout", $signed(dout_a), 0);
    check("rst_vout_z", int'(vout_z), 0);

    // Impulse: all b=64, 200 then zeros -> eleven 50s then 0.
    load_all(9'd64);
    push_impulse_seq();
    vin = 1'b1; din = 9'd200;
    tick();
    check("imp_lat_a", int'(vout_a), 0);
    check("imp_vout_z", int'(vout_z), 1);
    check("imp_dout_z", $signed(dout_z), 50);
    din = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      check("imp_vout", int'(vout_a), 1);
      check("imp_dout", $signed(dout_a), $signed(exp_v));
      check("imp_dout_z_seq", $signed(dout_z), (i <= 9) ? 50 : 0);
    end
    vin = 1'b0;
    tick();

    // Saturation and wrap: all b=255.
    load_all(9'd255);
    vin = 1'b1; din = 9'd255;
    repeat (12) tick();
    check("sat_pos", $signed(dout_a), 255);
    check("wrap_pos", $signed(dout_w), 234);
    check("sat_pos_z", $signed(dout_z), 255);
    din = 9'h100;
    repeat (12) tick();
    check("sat_neg", $signed(dout_a), -256);
    check("wrap_neg", $signed(dout_w), -245);
    check("sat_neg_z", $signed(dout_z), -256);
    vin = 1'b0;
    tick();
    last_exp = -256;

    // VIN gaps: pattern 1,0,0,1,0,1 must reproduce the impulse sequence.
    clr = 1'b1; tick(); clr = 1'b0;
    load_all(9'd64);
    push_impulse_seq();
    acc_cnt = 0;
    prev = 1'b0;
    for (int j = 0; j < 25; j++) begin
      vin = (acc_cnt < 12) ? (pat[j % 6] != 0) : 1'b0;
      din = (acc_cnt == 0) ? 9'd200 : 9'd0;
      tick();
      check("gap_vout", int'(vout_a), int'(prev));
      if (prev) begin
        exp_v = exp_q.pop_front();
        last_exp = $signed(exp_v);
        check("gap_dout", $signed(dout_a), last_exp);
      end else begin
        check("gap_hold", $signed(dout_a), last_exp);
      end
      if (vin) acc_cnt++;
      prev = vin;
    end
    vin = 1'b0;
    check("gap_queue_empty", exp_q.size(), 0);

    // Coefficient write race on b0 (64 -> 128) with a same-edge sample.
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 9'd128;
    vin = 1'b1; din = 9'd100;
    tick();
    coef_we = 1'b0; vin = 1'b0; din = '0;
    check("race_vout_z", int'(vout_z), 1);
    check("race_dout_z", $signed(dout_z), 25);
    tick();
    check("race_vout", int'(vout_a), 1);
    check("race_dout", $signed(dout_a), 25);
    send_chk(9'd100, 75, "race_next");

    // Out-of-range addresses must not touch any coefficient.
    for (int a = 11; a < 16; a++) write_coef(4'(a), 9'd127);
    clr = 1'b1; tick(); clr = 1'b0;
    send_chk(9'd100, 50, "oor_b0");
    for (int k = 1; k < 5; k++) send_chk(9'd0, 25, "oor_bk");

    // Flush mid-stream: the same-edge sample is dropped, and so is the pending one.
    vin = 1'b1; din = 9'd100;
    tick();
    din = 9'd50; clr = 1'b1;
    tick();
    clr = 1'b0; vin = 1'b0; din = '0;
    check("clr_vout", int'(vout_a), 0);
    check("clr_vout_z", int'(vout_z), 0);
    tick();
    check("clr_drop", int'(vout_a), 0);
    send_chk(9'd100, 50, "clr_clean");
    send_chk(9'd0, 25, "clr_clean1");

    // Asynchronous reset between edges, with a sample in flight.
    vin = 1'b1; din = 9'd100;
    tick();
    vin = 1'b0; din = '0;
    #2 rst = 1'b1;
    #1;
    check("arst_dout", $signed(dout_a), 0);
    check("arst_vout", int'(vout_a), 0);
    check("arst_vout_z", int'(vout_z), 0);
    check("arst_dout_z", $signed(dout_z), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_vout", int'(vout_a), 0);
      check("arst_no_vout_z", int'(vout_z), 0);
    end
    send_chk(9'd100, 0, "arst_coef0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
